// File: rtl/sprite_line_fetcher.sv
// Sprite scanline fetcher: copies one sprite row from the sprite ROM into a
// register line buffer during blanking, then replays it as keyed pixels.
module sprite_line_fetcher #(
    parameter int          SPR_W   = 30,
    parameter int          SPR_H   = 46,
    parameter int          FRAMES  = 2,
    parameter logic [5:0]  KEY_RGB = 6'b110011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic [1:0]  frame_sel,
    input  logic        flip,
    input  logic [9:0]  pixel_x,
    input  logic        pixel_valid,
    output logic [11:0] rom_addr,
    input  logic [5:0]  rom_rgb,
    output logic [5:0]  pix_rgb,
    output logic        pix_opaque,
    output logic        busy,
    output logic        fetch_done
);
    localparam int COL_W    = $clog2(SPR_W);
    localparam int FRAME_SZ = SPR_W * SPR_H;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [11:0]        rom_addr_q, rom_addr_d;
    logic [9:0]         sprite_x_q, sprite_x_d;
    logic               flip_q, flip_d;
    logic               line_valid_q, line_valid_d;
    logic               busy_q, busy_d;
    logic               fetch_done_q, fetch_done_d;
    logic [5:0]         pix_rgb_q, pix_rgb_d;
    logic               pix_opaque_q, pix_opaque_d;

    logic [6:0]         line_buf [SPR_W];

    logic [10:0]        row;
    logic               row_ok;
    logic [1:0]         frame_c;
    logic [11:0]        base;
    logic               last_col;
    logic               buf_we;
    logic [COL_W-1:0]   wr_idx;
    logic [10:0]        diff;
    logic               hit;
    logic [COL_W-1:0]   rd_idx;

    // Row and base address are evaluated from the live inputs so the first
    // ROM address is already valid in the cycle after line_start.
    always_comb begin
        row      = {1'b0, line_y} - {1'b0, sprite_y};
        row_ok   = !row[10] && (row < 11'(SPR_H));
        frame_c  = (int'(frame_sel) >= FRAMES) ? 2'(FRAMES - 1) : frame_sel;
        base     = 12'(int'(frame_c) * FRAME_SZ + int'(row) * SPR_W);
        last_col = (col_q == COL_W'(SPR_W - 1));
        wr_idx   = flip_q ? (COL_W'(SPR_W - 1) - col_q) : col_q;
        buf_we   = (state_q == FETCH) && !line_start;
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        rom_addr_d   = rom_addr_q;
        sprite_x_d   = sprite_x_q;
        flip_d       = flip_q;
        line_valid_d = line_valid_q;
        busy_d       = busy_q;
        fetch_done_d = 1'b0;

        if (line_start) begin
            sprite_x_d   = sprite_x;
            flip_d       = flip;
            line_valid_d = 1'b0;
            col_d        = '0;
            if (row_ok) begin
                state_d    = FETCH;
                busy_d     = 1'b1;
                rom_addr_d = base;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end else if (state_q == FETCH) begin
            col_d = col_q + COL_W'(1);
            if (last_col) begin
                state_d      = IDLE;
                busy_d       = 1'b0;
                line_valid_d = 1'b1;
                fetch_done_d = 1'b1;
            end else begin
                rom_addr_d = rom_addr_q + 12'd1;
            end
        end
    end

    // Display side: 11-bit compare so columns past 1023 never wrap into a hit.
    always_comb begin
        diff         = {1'b0, pixel_x} - {1'b0, sprite_x_q};
        hit          = line_valid_q && pixel_valid && !diff[10] && (diff < 11'(SPR_W));
        rd_idx       = diff[COL_W-1:0];
        pix_rgb_d    = 6'd0;
        pix_opaque_d = 1'b0;
        if (hit) begin
            pix_rgb_d    = line_buf[rd_idx][6:1];
            pix_opaque_d = line_buf[rd_idx][0];
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[wr_idx] <= {rom_rgb, rom_rgb != KEY_RGB};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            rom_addr_q   <= 12'd0;
            sprite_x_q   <= 10'd0;
            flip_q       <= 1'b0;
            line_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            fetch_done_q <= 1'b0;
            pix_rgb_q    <= 6'd0;
            pix_opaque_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            rom_addr_q   <= rom_addr_d;
            sprite_x_q   <= sprite_x_d;
            flip_q       <= flip_d;
            line_valid_q <= line_valid_d;
            busy_q       <= busy_d;
            fetch_done_q <= fetch_done_d;
            pix_rgb_q    <= pix_rgb_d;
            pix_opaque_q <= pix_opaque_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign busy       = busy_q;
    assign fetch_done = fetch_done_q;
    assign pix_rgb    = pix_rgb_q;
    assign pix_opaque = pix_opaque_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Bench for sprite_line_fetcher: ROM model, fetch address/timing checks,
// table-driven display vectors and randomized lines against a row model.
module tb_sprite_line_fetcher;
    localparam int         SPR_W  = 30;
    localparam int         SPR_H  = 46;
    localparam int         FRAMES = 2;
    localparam logic [5:0] KEY    = 6'b110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  line_y = '0, sprite_x = '0, sprite_y = '0, pixel_x = '0;
    logic [1:0]  frame_sel = '0;
    logic        flip = 1'b0, pixel_valid = 1'b0;
    logic [11:0] rom_addr;
    logic [5:0]  rom_rgb, pix_rgb;
    logic        pix_opaque, busy, fetch_done;

    logic [5:0]  rom [4096];
    assign rom_rgb = rom[rom_addr];

    int n_checks = 0;
    int n_err    = 0;

    // Model of the most recently completed line.
    bit m_valid = 0;
    int m_sx = 0, m_base = 0, m_last_addr = 0;
    bit m_flip = 0;

    sprite_line_fetcher #(.SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .KEY_RGB(KEY)) dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_y(line_y),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_sel(frame_sel), .flip(flip),
        .pixel_x(pixel_x), .pixel_valid(pixel_valid), .rom_addr(rom_addr),
        .rom_rgb(rom_rgb), .pix_rgb(pix_rgb), .pix_opaque(pix_opaque),
        .busy(busy), .fetch_done(fetch_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model_pix(input int px, input bit pv);
        int d, src;
        logic [5:0] c;
        d = px - m_sx;
        if (!m_valid || !pv || d < 0 || d >= SPR_W) return 0;
        src = m_flip ? (SPR_W - 1 - d) : d;
        c = rom[m_base + src];
        return {25'd0, c, c != KEY};
    endfunction

    task automatic start_line(input int ly, input int sx, input int sy, input int fs, input bit flp);
        line_y = 10'(ly); sprite_x = 10'(sx); sprite_y = 10'(sy);
        frame_sel = 2'(fs); flip = flp;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        m_valid = 0;
    endtask

    task automatic do_fetch(input int ly, input int sx, input int sy, input int fs, input bit flp);
        int r, base;
        bit inr;
        r    = ly - sy;
        inr  = (r >= 0) && (r < SPR_H);
        base = ((fs >= FRAMES) ? FRAMES - 1 : fs) * SPR_W * SPR_H + r * SPR_W;
        start_line(ly, sx, sy, fs, flp);
        if (inr) begin
            for (int k = 0; k < SPR_W; k++) begin
                chk("fetch_addr", int'(rom_addr), base + k);
                chk("fetch_busy", int'(busy), 1);
                chk("fetch_done_early", int'(fetch_done), 0);
                tick();
            end
            chk("fetch_done_pulse", int'(fetch_done), 1);
            chk("busy_after_fetch", int'(busy), 0);
            m_valid = 1; m_sx = sx; m_base = base; m_flip = flp;
            m_last_addr = base + SPR_W - 1;
            tick();
            chk("fetch_done_single", int'(fetch_done), 0);
            chk("addr_hold", int'(rom_addr), m_last_addr);
            $display("fetch ly=%0d sy=%0d sx=%0d frame=%0d flip=%0d base=%0d", ly, sy, sx, fs, flp, base);
        end else begin
            for (int k = 0; k < SPR_W + 2; k++) begin
                chk("oor_busy", int'(busy), 0);
                chk("oor_done", int'(fetch_done), 0);
                chk("oor_addr_hold", int'(rom_addr), m_last_addr);
                tick();
            end
            $display("no-fetch ly=%0d sy=%0d (row out of range)", ly, sy);
        end
    endtask

    task automatic check_pixel(input int px, input bit pv);
        int e;
        pixel_x = 10'(px); pixel_valid = pv;
        e = model_pix(px & 1023, pv);
        tick();
        chk("pix_rgb", int'(pix_rgb), e >> 1);
        chk("pix_opaque", int'(pix_opaque), e & 1);
        $display("pixel x=%0d valid=%0d rgb=%0d opaque=%0d", px & 1023, pv, pix_rgb, pix_opaque);
        pixel_valid = 1'b0;
    endtask

    task automatic sweep_transparent(input string nm);
        int bad;
        bad = 0;
        pixel_valid = 1'b1;
        for (int px = 0; px < 1024; px++) begin
            pixel_x = 10'(px);
            tick();
            if (pix_opaque !== 1'b0 || pix_rgb !== 6'd0) bad++;
        end
        pixel_valid = 1'b0;
        chk(nm, bad, 0);
        $display("sweep %s: opaque pixels=%0d", nm, bad);
    endtask

    typedef struct {
        bit         flp;
        int         px;
        bit         pv;
        logic [5:0] rgb;
        bit         op;
    } vec_t;

    initial begin
        vec_t vecs [10];
        int   cur_flip;

        for (int i = 0; i < 4096; i++)
            rom[i] = ($urandom_range(0, 7) == 0) ? KEY : 6'($urandom);
        rom[0] = 6'b111000; rom[3] = KEY; rom[5] = 6'b000100; rom[29] = 6'b001010;

        vecs[0] = '{0, 105, 1, 6'b000100, 1};
        vecs[1] = '{0,  99, 1, 6'b000000, 0};
        vecs[2] = '{0, 130, 1, 6'b000000, 0};
        vecs[3] = '{0, 103, 1, KEY,       0};
        vecs[4] = '{0, 105, 0, 6'b000000, 0};
        vecs[5] = '{0, 100, 1, 6'b111000, 1};
        vecs[6] = '{0, 129, 1, 6'b001010, 1};
        vecs[7] = '{1, 100, 1, 6'b001010, 1};
        vecs[8] = '{1, 129, 1, 6'b111000, 1};
        vecs[9] = '{1, 126, 1, KEY,       0};

        // Reset state
        #2;
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(fetch_done), 0);
        chk("rst_rgb", int'(pix_rgb), 0);
        chk("rst_opaque", int'(pix_opaque), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_pixel(100, 1);

        // Table-driven display vectors on the test-plan line
        cur_flip = -1;
        for (int i = 0; i < 10; i++) begin
            if (int'(vecs[i].flp) != cur_flip) begin
                do_fetch(50, 100, 50, 0, vecs[i].flp);
                cur_flip = int'(vecs[i].flp);
            end
            pixel_x = 10'(vecs[i].px); pixel_valid = vecs[i].pv;
            tick();
            pixel_valid = 1'b0;
            chk("vec_rgb", int'(pix_rgb), int'(vecs[i].rgb));
            chk("vec_opaque", int'(pix_opaque), int'(vecs[i].op));
            $display("vector %0d flip=%0d x=%0d rgb=%0d opaque=%0d", i, vecs[i].flp, vecs[i].px, pix_rgb, pix_opaque);
        end

        // Frame selection and clamping
        do_fetch(51, 100, 50, 1, 0);
        check_pixel(110, 1);
        do_fetch(51, 100, 50, 3, 0);
        check_pixel(110, 1);

        // Rows just outside the sprite
        do_fetch(96, 100, 50, 0, 0);
        sweep_transparent("oor_row46");
        do_fetch(49, 100, 50, 0, 0);
        sweep_transparent("oor_row_neg");

        // Abort 10 cycles into a fetch
        do_fetch(50, 100, 50, 0, 0);
        start_line(60, 200, 50, 0, 0);
        for (int k = 0; k < 10; k++) begin
            chk("abort_no_done", int'(fetch_done), 0);
            tick();
        end
        do_fetch(51, 200, 50, 1, 1);
        check_pixel(200, 1);
        check_pixel(229, 1);

        // line_start coinciding with the final fetch cycle
        start_line(55, 300, 50, 0, 0);
        for (int k = 0; k < SPR_W - 1; k++) tick();
        do_fetch(52, 310, 50, 1, 0);
        check_pixel(315, 1);

        // Reset mid-fetch
        start_line(70, 400, 50, 0, 0);
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", int'(rom_addr), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(fetch_done), 0);
        chk("mid_rst_opaque", int'(pix_opaque), 0);
        m_valid = 0; m_last_addr = 0;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < SPR_W + 2; k++) begin
            chk("post_rst_done", int'(fetch_done), 0);
            chk("post_rst_busy", int'(busy), 0);
            tick();
        end
        check_pixel(405, 1);

        // Randomized lines against the model
        for (int it = 0; it < 40; it++) begin
            int sx, sy, ly, fs;
            bit flp;
            sx  = $urandom_range(0, 1023);
            sy  = $urandom_range(0, 1023);
            ly  = (sy + $urandom_range(0, 55) - 5) & 1023;
            fs  = $urandom_range(0, 3);
            flp = 1'($urandom_range(0, 1));
            do_fetch(ly, sx, sy, fs, flp);
            for (int p = 0; p < 6; p++)
                check_pixel((sx + $urandom_range(0, 40) - 5) & 1023, 1'($urandom_range(0, 5) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sprite_line_fetcher.md
# sprite_line_fetcher

- Reads one scanline of a sprite from a sprite ROM (12-bit address in, 6-bit RGB out, combinational read) into an internal line buffer during horizontal blanking.
- Replays that line as pixels, with an opacity flag, while the display scans across it.
- Sits between the VGA timing generator and the colour mux, as the consumer/addresser of the sprite ROMs.
- Adds animation frame selection, horizontal mirroring and colour-key transparency.

## Interface

Parameters:
- SPR_W, 30: sprite width in pixels.
- SPR_H, 46: sprite height in rows.
- FRAMES, 2: animation frames stored back-to-back in the ROM; FRAMES*SPR_W*SPR_H ≤ 4096.
- KEY_RGB, 6'b110011: transparent colour key.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle pulse at start of horizontal blanking.
- line_y  in  10  scanline about to be displayed; sampled on line_start.
- sprite_x  in  10  sprite left edge; sampled on line_start.
- sprite_y  in  10  sprite top row; sampled on line_start.
- frame_sel  in  2  animation frame; sampled on line_start.
- flip  in  1  mirror horizontally; sampled on line_start.
- pixel_x  in  10  current display column.
- pixel_valid  in  1  active-video qualifier.
- rom_addr  out  12  address to sprite ROM.
- rom_rgb  in  6  ROM data; valid in the same cycle as rom_addr.
- pix_rgb  out  6  sprite colour for the requested pixel.
- pix_opaque  out  1  1 = sprite covers the pixel and the colour is not KEY_RGB.
- busy  out  1  fetch in progress.
- fetch_done  out  1  one-cycle pulse when a line fetch completes.

## Operation

- FSM states: IDLE, FETCH.
- line_start in any state:
  - Latch sprite_x, sprite_y, flip and the clamped frame (frame_sel ≥ FRAMES → FRAMES-1).
  - Compute row = line_y − sprite_y using 11-bit arithmetic.
  - Clear line_valid.
  - If 0 ≤ row < SPR_H: go to FETCH, col = 0. Otherwise go to IDLE.
  - A line_start during FETCH aborts the current fetch and restarts it with the new values.
- FETCH:
  - rom_addr = frame*SPR_W*SPR_H + row*SPR_W + col, driven from registered values.
  - Each cycle, write buf[flip ? SPR_W-1-col : col] = {rom_rgb, rom_rgb != KEY_RGB}, then col++.
  - After col = SPR_W-1 is written: set line_valid, pulse fetch_done, return to IDLE.
- rom_addr holds its last value in IDLE.
- Display side:
  - hit = line_valid & pixel_valid & pixel_x ≥ sprite_x_l & (pixel_x − sprite_x_l) < SPR_W.
  - Compare in 11 bits; no wrap at column 1023.
  - If hit: pix_rgb = buf[pixel_x − sprite_x_l].rgb and pix_opaque = buf[...].opaque.
  - Otherwise: pix_rgb = 0, pix_opaque = 0.
- While busy, line_valid = 0, so outputs are transparent.
- The line buffer is SPR_W entries × 7 bits, in registers.

## Timing

- Reset values: rom_addr = 0, pix_rgb = 0, pix_opaque = 0, busy = 0, fetch_done = 0, state IDLE, line_valid = 0. Buffer contents are don't-care.
- line_start at edge T (in-range row): busy = 1 from T+1.
- rom_addr = base + k during cycle T+1+k, for k = 0..SPR_W-1.
- fetch_done pulses in cycle T+SPR_W+1. busy = 0 and line_valid = 1 in the same cycle.
- Fetch latency is SPR_W+1 cycles and must fit within horizontal blanking.
- Display latency: pixel_x/pixel_valid presented in cycle N → pix_rgb/pix_opaque registered, visible in cycle N+1.
- Out-of-range line_start: busy stays 0, no fetch_done pulse, line_valid = 0 from T+1.
- Reset asserted mid-fetch: immediately returns to reset values; no fetch_done pulse.
- fetch_done and line_start in the same cycle: line_start wins; line_valid = 0 and a new fetch starts.

## Test plan

- sprite_x=100, sprite_y=50, line_y=50, frame_sel=0, flip=0:
  - rom_addr steps 0..29 over 30 cycles, then fetch_done.
  - With ROM entry 5 = 6'b000100 and pixel_x=105 → pix_rgb=6'b000100, pix_opaque=1 one cycle later.
  - pixel_x=99 and pixel_x=130 → pix_opaque=0.
- line_y=51, frame_sel=1: rom_addr steps 1410..1439.
- frame_sel=3 clamps to frame 1, so the same addresses are generated.
- flip=1, line_y=50: pixel_x=100 returns the colour fetched from addr 29; pixel_x=129 returns addr 0.
- ROM word equal to 6'b110011 at column 3: pixel_x=103 → pix_opaque=0.
- line_y=96 (row = 46) and line_y=49:
  - no rom_addr stepping, busy=0, no fetch_done pulse;
  - pix_opaque=0 across the whole line.
- Abort and reset cases:
  - Second line_start 10 cycles into a fetch → addresses restart from the new base, exactly one fetch_done pulse, 30 cycles after the second line_start.
  - rst_n low mid-fetch → all outputs 0 asynchronously, busy=0, no fetch_done pulse.
